vector_data_mem: RTL
====================

VECTOR_DATA_MEM -- requirements
Module: vector_data_mem

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the array, power of two.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-003 Parameter WAIT_CYCLES, default 2, range 1..15: grant stall length; used only when VECTOR_DATA_MEM_WAIT_EN is defined.
REQ-004 Ports:
- clk, input, 1: single clock; all logic on rising edge.
- n_reset, input, 1: reset, synchronous and active-low.
- data_req_i, input, 1: initiator request.
- data_gnt_o, output, 1: request accepted this cycle.
- data_we_i, input, 1: 1 = write, 0 = read.
- data_be_i, input, 4: byte enables.
- data_addr_i, input, 32: byte address.
- data_wdata_i, input, 32: write data.
- data_rvalid_o, output, 1: response valid.
- data_rdata_o, output, 32: read data, qualified by data_rvalid_o.
- data_err_o, output, 1: out-of-range access, qualified by data_rvalid_o.

Function
REQ-005 A request is accepted in any cycle where data_req_i and data_gnt_o are both 1.
REQ-006 For every accepted request, read or write, data_rvalid_o shall be 1 for exactly one cycle, one cycle after acceptance.
REQ-007 Back-to-back acceptances on consecutive cycles shall each get their own response on consecutive cycles.
REQ-008 Word index = (data_addr_i - BASE_ADDR) >> 2. data_addr_i[1:0] is ignored.
REQ-009 An access is in range when (data_addr_i - BASE_ADDR), taken unsigned, is < 4*DEPTH_WORDS.
REQ-010 An accepted in-range write shall update only the bytes whose data_be_i bit is 1, at the acceptance edge.
REQ-011 An in-range read shall return the full 32-bit word on data_rdata_o, regardless of data_be_i.
REQ-012 A read accepted in the cycle after a write to the same word shall return the newly written bytes.
REQ-013 Out-of-range access:
- a write shall not modify the array;
- a read shall return 32'h0;
- data_err_o shall be 1 together with that access's rvalid.
REQ-014 data_rdata_o shall be 32'h0 in any response cycle belonging to a write.
REQ-015 data_rdata_o and data_err_o shall hold their last values while data_rvalid_o is 0.
REQ-016 An access with data_be_i = 4'b0000 shall still be accepted and answered. A write of this kind changes nothing.

Reset
REQ-017 While n_reset is 0 at a clock edge, the following shall all be 0 after that edge: data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o, FSM state (IDLE) and stall counter.
REQ-018 Reset mid-operation shall discard any pending response; no rvalid is issued for it. The array contents are not reset.
REQ-019 data_req_i sampled while n_reset is 0 shall not be accepted.

Configuration
REQ-020 Macro VECTOR_DATA_MEM_WAIT_EN, undefined: data_gnt_o = data_req_i, combinational, forced 0 while n_reset is 0. There is no FSM.
REQ-021 Macro VECTOR_DATA_MEM_WAIT_EN, defined: a three-state FSM drives data_gnt_o as follows.
- IDLE: on data_req_i = 1, go to STALL and load the counter with WAIT_CYCLES-1. data_gnt_o = 0.
- STALL: decrement the counter; when it reaches 0, go to GRANT. data_gnt_o = 0.
- GRANT: data_gnt_o = 1 and the request is accepted. Go to IDLE.
- Net effect: first grant occurs exactly WAIT_CYCLES+1 cycles after req rises from IDLE.
- The initiator holds req and payload stable until gnt. If req drops during STALL, return to IDLE without acceptance.

Structure
REQ-022 accelerator_pkg shall hold:
- typedef dmem_state_t {DMEM_IDLE, DMEM_STALL, DMEM_GRANT};
- constant DMEM_BE_WIDTH = 4.
REQ-023 The byte-enabled storage array shall be the sub-module dmem_sram:
- one write and one read port;
- registered read data;
- no reset on storage.

Verification
REQ-024 No macro; write addr 0x10, data 0xDEADBEEF, be 4'hF. Then read 0x10 -> gnt in the request cycle, rvalid 1 cycle later, rdata 0xDEADBEEF, err 0.
REQ-025 Partial write addr 0x10, data 0x11223344, be 4'b0101 over 0xDEADBEEF, then read -> 0xDE22BE44.
REQ-026 Four back-to-back reads 0x0, 0x4, 0x8, 0xC with req held high -> four consecutive rvalid cycles, in order.
REQ-027 Read and write at BASE_ADDR + 4*DEPTH_WORDS -> rdata 0, err 1 with rvalid. A following read of word 0 is unchanged.
REQ-028 Macro defined, WAIT_CYCLES = 3; req rises at cycle 0 -> gnt only at cycle 4, rvalid at cycle 5.
REQ-029 n_reset low for 1 cycle in the cycle after acceptance -> no rvalid is issued; the next request completes normally.

Source files
------------

// File: rtl/accelerator_pkg.sv
// Shared types and constants for the vector data memory.
package accelerator_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE  = 2'd0,
        DMEM_STALL = 2'd1,
        DMEM_GRANT = 2'd2
    } dmem_state_t;

    localparam int DMEM_BE_WIDTH = 4;

endpackage

// File: rtl/dmem_sram.sv
// Byte-enabled word array: one write port, one registered read port.
module dmem_sram
    import accelerator_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [DMEM_BE_WIDTH-1:0] i_be,
    input  logic [AW-1:0]            i_waddr,
    input  logic [31:0]              i_wdata,
    input  logic                     i_re,
    input  logic [AW-1:0]            i_raddr,
    output logic [31:0]              o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < DMEM_BE_WIDTH; b++) begin
                if (i_be[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vector_data_mem.sv
// Data memory with req/gnt/rvalid protocol and range checking.
// VECTOR_DATA_MEM_WAIT_EN adds a WAIT_CYCLES grant stall FSM.
module vector_data_mem
    import accelerator_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     data_req_i,
    output logic                     data_gnt_o,
    input  logic                     data_we_i,
    input  logic [DMEM_BE_WIDTH-1:0] data_be_i,
    input  logic [31:0]              data_addr_i,
    input  logic [31:0]              data_wdata_i,
    output logic                     data_rvalid_o,
    output logic [31:0]              data_rdata_o,
    output logic                     data_err_o
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LP_SPAN = 32'(4 * DEPTH_WORDS);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("vector_data_mem: WAIT_CYCLES must be 1..15");
    end

    logic [31:0] w_offset;
    logic        w_in_range;
    logic        w_accept;
    logic        w_gnt;
    logic [31:0] w_sram_rdata;

    logic r_rvalid;
    logic r_err;
    logic r_rd_sel;

    // Unsigned subtraction makes addresses below BASE_ADDR wrap out of range.
    assign w_offset   = data_addr_i - BASE_ADDR;
    assign w_in_range = (w_offset < LP_SPAN);
    assign data_gnt_o = w_gnt & n_reset;
    assign w_accept   = data_req_i & data_gnt_o;

`ifdef VECTOR_DATA_MEM_WAIT_EN
    dmem_state_t r_state;
    dmem_state_t w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state <= DMEM_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gnt       = 1'b0;
        unique case (r_state)
            DMEM_IDLE: begin
                if (data_req_i) begin
                    w_state_nxt = DMEM_STALL;
                    w_cnt_nxt   = 4'(WAIT_CYCLES - 1);
                end
            end
            DMEM_STALL: begin
                if (!data_req_i) begin
                    w_state_nxt = DMEM_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = DMEM_GRANT;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            DMEM_GRANT: begin
                w_gnt       = 1'b1;
                w_state_nxt = DMEM_IDLE;
            end
            default: w_state_nxt = DMEM_IDLE;
        endcase
    end
`else
    assign w_gnt = data_req_i;
`endif

    dmem_sram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_accept & data_we_i & w_in_range),
        .i_be    (data_be_i),
        .i_waddr (w_offset[AW+1:2]),
        .i_wdata (data_wdata_i),
        .i_re    (w_accept & ~data_we_i & w_in_range),
        .i_raddr (w_offset[AW+1:2]),
        .o_rdata (w_sram_rdata)
    );

    // Response flags only move on acceptance, so outputs hold between responses.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rd_sel <= 1'b0;
        end else begin
            r_rvalid <= w_accept;
            if (w_accept) begin
                r_err    <= ~w_in_range;
                r_rd_sel <= ~data_we_i & w_in_range;
            end
        end
    end

    assign data_rvalid_o = r_rvalid & n_reset;
    assign data_rdata_o  = r_rd_sel ? w_sram_rdata : 32'h0;
    assign data_err_o    = r_err;

endmodule
